// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the pipelined ALU and its testbench.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } alu_state_e;

    // MUL is only a legal opcode when the multiplier is built in.
    function automatic logic op_is_legal(input logic [3:0] op, input logic mul_en);
        logic legal;
        if (op == OP_MUL) begin
            legal = mul_en;
        end else begin
            legal = (op < OP_MUL);
        end
        return legal;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per clock, low WIDTH bits of the product.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             i_abort,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             r_busy;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic             w_count_zero;

    assign w_count_zero = (r_count == {CNT_W{1'b0}});

    // Done is seen one edge after the last bit step, giving a fixed WIDTH+1 latency.
    assign o_done    = r_busy & w_count_zero;
    assign o_busy    = r_busy;
    assign o_product = r_acc;

    // Operand load, per-bit accumulate/shift, and abort handling.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_busy   <= 1'b0;
            r_count  <= {CNT_W{1'b0}};
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_acc    <= {WIDTH{1'b0}};
        end else if (i_abort) begin
            r_busy  <= 1'b0;
            r_count <= {CNT_W{1'b0}};
            r_acc   <= {WIDTH{1'b0}};
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_count  <= CNT_W'(WIDTH);
            r_mcand  <= i_op_a;
            r_mplier <= i_op_b;
            r_acc    <= {WIDTH{1'b0}};
        end else if (r_busy && !w_count_zero) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - CNT_W'(1);
        end else if (o_done) begin
            r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_pipe_seq.sv
// WIDTH-bit ALU with valid/ready handshake, registered result and flags, and an
// iterative multiplier; holds one result until the consumer takes it.
module alu_pipe_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter bit MUL_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_in0,
    input  logic [WIDTH-1:0] alu_in1,
    input  logic [3:0]       control_signal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             ovf_flag,
    output logic             illegal_op
);

    alu_state_e       r_state;
    alu_state_e       w_state_nxt;
    logic             r_live;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;
    logic             r_illegal;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_legal;
    logic             w_is_mul;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_drain;
    logic             w_mul_start;
    logic             w_load_alu;
    logic             w_load_mul;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_product;

    assign w_sum    = {1'b0, alu_in0} + {1'b0, alu_in1};
    assign w_diff   = {1'b0, alu_in0} - {1'b0, alu_in1};
    assign w_shamt  = alu_in1[SHAMT_W-1:0];
    assign w_legal  = op_is_legal(control_signal, MUL_EN);
    assign w_is_mul = MUL_EN && (control_signal == OP_MUL);

    // r_live keeps in_ready low until the first edge after reset release.
    assign w_in_ready = r_live && (r_state == ST_IDLE) && !w_mul_busy
                        && (!r_out_valid || out_ready) && !flush;
    assign w_accept   = in_valid && w_in_ready;
    assign w_drain    = r_out_valid && out_ready;

    // Single-cycle datapath; MUL and illegal opcodes fall through to zero here.
    always_comb begin
        w_res   = {WIDTH{1'b0}};
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (control_signal)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (alu_in0[WIDTH-1] == alu_in1[WIDTH-1])
                          && (w_sum[WIDTH-1] != alu_in0[WIDTH-1]);
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (alu_in0[WIDTH-1] != alu_in1[WIDTH-1])
                          && (w_diff[WIDTH-1] != alu_in0[WIDTH-1]);
            end
            OP_AND:  w_res = alu_in0 & alu_in1;
            OP_OR:   w_res = alu_in0 | alu_in1;
            OP_XOR:  w_res = alu_in0 ^ alu_in1;
            OP_SLL:  w_res = alu_in0 << w_shamt;
            OP_SRL:  w_res = alu_in0 >> w_shamt;
            OP_SRA:  w_res = $signed(alu_in0) >>> w_shamt;
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (alu_in0 < alu_in1)};
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(alu_in0) < $signed(alu_in1))};
            default: w_res = {WIDTH{1'b0}};
        endcase
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .clear_n   (clear_n),
        .i_abort   (flush),
        .i_start   (w_mul_start),
        .i_op_a    (alu_in0),
        .i_op_b    (alu_in1),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    // Next state and load strobes; flush wins over MUL completion.
    always_comb begin
        w_state_nxt = r_state;
        w_mul_start = 1'b0;
        w_load_alu  = 1'b0;
        w_load_mul  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_mul_start = w_accept && w_is_mul;
                w_load_alu  = w_accept && !w_is_mul;
                if (w_mul_start) begin
                    w_state_nxt = ST_MUL_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MUL_RUN: begin
                w_load_mul = w_mul_done && !flush;
                if (flush || w_mul_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_MUL_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output register: load on completion, hold under backpressure, clear valid on drain.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_out_valid <= 1'b0;
            r_out       <= {WIDTH{1'b0}};
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load_alu) begin
            r_out_valid <= 1'b1;
            r_out       <= w_res;
            r_zero      <= (w_res == {WIDTH{1'b0}});
            r_carry     <= w_carry;
            r_ovf       <= w_ovf;
            r_illegal   <= !w_legal;
        end else if (w_load_mul) begin
            r_out_valid <= 1'b1;
            r_out       <= w_product;
            r_zero      <= (w_product == {WIDTH{1'b0}});
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign alu_out    = r_out;
    assign zero_flag  = r_zero;
    assign carry_flag = r_carry;
    assign ovf_flag   = r_ovf;
    assign illegal_op = r_illegal;

endmodule

// File: tb/tb_alu_pipe_seq.sv
// Directed self-checking bench for alu_pipe_seq at WIDTH=32.
module tb_alu_pipe_seq;
    import alu_pkg::*;

    logic        clk;
    logic        clear_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_in0;
    logic [31:0] alu_in1;
    logic [3:0]  control_signal;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out;
    logic        zero_flag;
    logic        carry_flag;
    logic        ovf_flag;
    logic        illegal_op;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;   // {zero, carry, ovf, illegal}
    } vec_t;

    alu_pipe_seq #(.WIDTH(32)) dut (
        .clk            (clk),
        .clear_n        (clear_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_in0        (alu_in0),
        .alu_in1        (alu_in1),
        .control_signal (control_signal),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_out        (alu_out),
        .zero_flag      (zero_flag),
        .carry_flag     (carry_flag),
        .ovf_flag       (ovf_flag),
        .illegal_op     (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        #2;
        checks++;
        if ({out_valid, alu_out} !== 33'd0) begin
            errors++; $display("FAIL reset_out: got valid=%b out=%h, want 0/0", out_valid, alu_out);
        end
        checks++;
        if ({zero_flag, carry_flag, ovf_flag, illegal_op} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b, want 0000", {zero_flag, carry_flag, ovf_flag, illegal_op});
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b, want 0", in_ready);
        end
        clear_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL release_in_ready: got %b, want 0 before first edge", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_edge: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_alu_ops;
        vec_t tbl [13];
        tbl = '{
            '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1100},
            '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0010},
            '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000},
            '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1000},
            '{OP_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 4'b0000},
            '{OP_SRL,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 4'b0000},
            '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0010},
            '{OP_SUB,  32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 4'b0100},
            '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0000},
            '{OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 4'b0000},
            '{OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 4'b0000},
            '{OP_SLL,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 4'b0000},
            '{4'd15,   32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1001}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            control_signal = tbl[i].op;
            alu_in0 = tbl[i].a;
            alu_in1 = tbl[i].b;
            in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL alu_ready[%0d]: got %b, want 1", i, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if ({out_valid, alu_out} !== {1'b1, tbl[i].res}) begin
                errors++; $display("FAIL alu_res[%0d]: got valid=%b out=%h, want 1/%h", i, out_valid, alu_out, tbl[i].res);
            end
            checks++;
            if ({zero_flag, carry_flag, ovf_flag, illegal_op} !== tbl[i].fl) begin
                errors++; $display("FAIL alu_flags[%0d]: got %b, want %b", i, {zero_flag, carry_flag, ovf_flag, illegal_op}, tbl[i].fl);
            end
        end
    endtask

    task automatic test_mul;
        int lat;
        bit rdy_bad;
        control_signal = OP_MUL;
        alu_in0 = 32'h0001_0003;
        alu_in1 = 32'h0000_0005;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        rdy_bad = 1'b0;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) rdy_bad = 1'b1;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) lat = k;
            else if (in_ready !== 1'b0) rdy_bad = 1'b1;
        end
        checks++;
        if (lat != 33) begin
            errors++; $display("FAIL mul_latency: got %0d edges (0 = none in 40), want 33", lat);
        end
        checks++;
        if (rdy_bad !== 1'b0) begin
            errors++; $display("FAIL mul_busy_ready: got in_ready/out_valid high during run, want low");
        end
        checks++;
        if (alu_out !== 32'h0005_000F) begin
            errors++; $display("FAIL mul_result: got %h, want 0005000f", alu_out);
        end
        checks++;
        if ({zero_flag, carry_flag, ovf_flag, illegal_op} !== 4'b0000) begin
            errors++; $display("FAIL mul_flags: got %b, want 0000", {zero_flag, carry_flag, ovf_flag, illegal_op});
        end
    endtask

    task automatic test_backpressure;
        bit hold_bad;
        @(negedge clk);
        checks++;
        if ({out_valid, alu_out} !== {1'b0, 32'h0005_000F}) begin
            errors++; $display("FAIL drain_only: got valid=%b out=%h, want 0/0005000f", out_valid, alu_out);
        end
        out_ready = 1'b0;
        control_signal = OP_ADD;
        alu_in0 = 32'd2;
        alu_in1 = 32'd3;
        in_valid = 1'b1;
        @(negedge clk);
        control_signal = OP_XOR;
        alu_in0 = 32'hA5A5_A5A5;
        alu_in1 = 32'hFFFF_0000;
        hold_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (out_valid !== 1'b1 || alu_out !== 32'd5 || in_ready !== 1'b0) hold_bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (hold_bad !== 1'b0) begin
            errors++; $display("FAIL bp_hold: result 5 not held or in_ready high under backpressure (now valid=%b out=%h)", out_valid, alu_out);
        end
        checks++;
        if ({out_valid, alu_out} !== {1'b1, 32'd5}) begin
            errors++; $display("FAIL bp_before_drain: got valid=%b out=%h, want 1/00000005", out_valid, alu_out);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready_rise: got %b, want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, alu_out} !== {1'b1, 32'h5A5A_A5A5}) begin
            errors++; $display("FAIL back_to_back: got valid=%b out=%h, want 1/5a5aa5a5", out_valid, alu_out);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_final_drain: got valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_abort;
        bit seen;
        control_signal = OP_MUL;
        alu_in0 = 32'd3;
        alu_in1 = 32'd4;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got %b during flush, want 0", in_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_idle: got in_ready=%b after flush, want 1", in_ready);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL flush_no_result: got out_valid high after flushed MUL, want never");
        end

        control_signal = OP_MUL;
        alu_in0 = 32'd6;
        alu_in1 = 32'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        clear_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, alu_out} !== 34'd0) begin
            errors++; $display("FAIL midmul_reset: got valid=%b ready=%b out=%h, want all 0", out_valid, in_ready, alu_out);
        end
        @(negedge clk);
        clear_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL reset_no_result: got out_valid high after reset MUL, want never");
        end

        control_signal = OP_ADD;
        alu_in0 = 32'd7;
        alu_in1 = 32'd8;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, alu_out, zero_flag, carry_flag, ovf_flag, illegal_op} !== {1'b1, 32'd15, 4'b0000}) begin
            errors++; $display("FAIL add_after_abort: got valid=%b out=%h, want 1/0000000f", out_valid, alu_out);
        end
        control_signal = 4'd12;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, alu_out, zero_flag, carry_flag, ovf_flag, illegal_op} !== {1'b1, 32'd0, 4'b1001}) begin
            errors++; $display("FAIL illegal_12: got valid=%b out=%h flags=%b, want 1/0/1001", out_valid, alu_out, {zero_flag, carry_flag, ovf_flag, illegal_op});
        end
    endtask

    initial begin
        clear_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        alu_in0 = 32'd0;
        alu_in1 = 32'd0;
        control_signal = 4'd0;
        test_reset();
        test_alu_ops();
        test_mul();
        test_backpressure();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
